// File: rtl/mem_access_arbiter.sv
// Requester-side controller for the unified single-port instruction/data
// memory. Serialises fetch and data requests onto one memory port using a
// req/ack handshake, chains back-to-back accesses with no idle cycle, raises
// the pipeline stall, and aborts accesses that the memory never acknowledges.
module mem_access_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_pc,
    output logic              o_if_ready,
    output logic [DATA_W-1:0] o_if_instr,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ready,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_req,
    output logic              o_mem_select,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          r_count;
    logic                r_we;
    logic                r_err;
    logic                r_mem_select;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_in_fetch;
    logic                w_in_data;
    logic                w_busy;
    logic                w_expired;
    logic                w_done;
    logic                w_timeout;
    logic                w_grant_fetch;
    logic                w_grant_data;
    logic                w_if_ready;
    logic                w_dm_ready;

    // An access finishes on mem_ack or when the counter hits the limit; an ack
    // in the limit cycle wins, so that case is a normal completion.
    assign w_in_fetch = (r_state == FETCH);
    assign w_in_data  = (r_state == DATA);
    assign w_busy     = w_in_fetch | w_in_data;
    assign w_expired  = (r_count == TIMEOUT_CNT);
    assign w_done     = w_busy & (i_mem_ack | w_expired);
    assign w_timeout  = w_busy & w_expired & ~i_mem_ack;

    // Next-state and grant decisions: data beats fetch from IDLE, and on
    // completion the other requester is chained in, never the one just served.
    always_comb begin
        w_next_state  = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_dm_req) begin
                    w_grant_data = 1'b1;
                    w_next_state = DATA;
                end else if (i_if_req) begin
                    w_grant_fetch = 1'b1;
                    w_next_state  = FETCH;
                end
            end
            FETCH: begin
                if (w_done) begin
                    if (i_dm_req) begin
                        w_grant_data = 1'b1;
                        w_next_state = DATA;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_done) begin
                    if (i_if_req) begin
                        w_grant_fetch = 1'b1;
                        w_next_state  = FETCH;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the granted request onto the memory port, run the latency counter
    // and record a timeout in the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= 8'd0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_mem_select <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (w_grant_data) begin
                r_mem_select <= 1'b0;
                r_mem_addr   <= i_dm_addr;
                r_mem_wdata  <= i_dm_wdata;
                r_we         <= i_dm_we;
                r_count      <= 8'd0;
            end else if (w_grant_fetch) begin
                r_mem_select <= 1'b1;
                r_mem_addr   <= i_if_pc;
                r_mem_wdata  <= '0;
                r_we         <= 1'b0;
                r_count      <= 8'd0;
            end else if (w_done) begin
                r_count <= 8'd0;
            end else if (w_busy) begin
                r_count <= r_count + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Completion strobes and pass-through data; a timed-out access returns 0
    // so the pipeline sees a NOP or a zero load, and reset suppresses strobes.
    assign w_if_ready   = w_in_fetch & w_done & ~i_rst;
    assign w_dm_ready   = w_in_data & w_done & ~i_rst;
    assign o_if_ready   = w_if_ready;
    assign o_dm_ready   = w_dm_ready;
    assign o_if_instr   = (w_if_ready & i_mem_ack) ? i_mem_rdata : '0;
    assign o_dm_rdata   = (w_dm_ready & i_mem_ack & ~r_we) ? i_mem_rdata : '0;

    assign o_mem_req    = w_busy;
    assign o_mem_select = r_mem_select;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wren   = w_in_data & r_we;
    assign o_err        = r_err;

    assign o_stall = (i_if_req & ~w_if_ready) | (i_dm_req & ~w_dm_ready);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter. The bench plays both the
// pipeline and the memory: it knows each access's ack latency up front, so it
// predicts at transaction level which requester is served, in what order, in
// which cycle it completes and what data it returns.
module tb_mem_access_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifReq;
    logic [AW-1:0] ifPc;
    logic          ifReady;
    logic [DW-1:0] ifInstr;
    logic          dmReq;
    logic          dmWe;
    logic [AW-1:0] dmAddr;
    logic [DW-1:0] dmWdata;
    logic          dmReady;
    logic [DW-1:0] dmRdata;
    logic          memReq;
    logic          memSelect;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memWren;
    logic          memAck;
    logic [DW-1:0] memRdata;
    logic          stall;
    logic          err;

    int   checks = 0;
    int   passes = 0;
    logic expErr = 1'b0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(ifReq), .i_if_pc(ifPc), .o_if_ready(ifReady), .o_if_instr(ifInstr),
        .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_addr(dmAddr), .i_dm_wdata(dmWdata),
        .o_dm_ready(dmReady), .o_dm_rdata(dmRdata),
        .o_mem_req(memReq), .o_mem_select(memSelect), .o_mem_addr(memAddr),
        .o_mem_wdata(memWdata), .o_mem_wren(memWren),
        .i_mem_ack(memAck), .i_mem_rdata(memRdata),
        .o_stall(stall), .o_err(err)
    );

    // Serve the requested accesses (data before fetch) with the given ack
    // latencies; a latency beyond TO+1 never acks and must time out in the
    // cycle where the access has been pending TO cycles. Starts just after a
    // rising edge with the DUT idle and ends the same way.
    task automatic run_batch(input bit doF, input bit doD,
                             input logic [AW-1:0] pc, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input bit we,
                             input logic [DW-1:0] rdF, input logic [DW-1:0] rdD,
                             input int latF, input int latD);
        bit  isF [2];
        int  lat [2];
        int  n;
        int  c;
        bit  done;
        bit  ack;
        bit  tmo;
        logic [DW-1:0] rd;
        logic [DW-1:0] expData;
        n = 0;
        if (doD) begin isF[n] = 1'b0; lat[n] = latD; n++; end
        if (doF) begin isF[n] = 1'b1; lat[n] = latF; n++; end
        ifReq = doF; ifPc = pc; dmReq = doD; dmWe = we; dmAddr = addr; dmWdata = wd;
        memAck = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0) $display("[TB] FAIL grant_cycle_mem_req: got %b expected 0", memReq);
        else passes++;
        checks++;
        if (stall !== (doF | doD)) $display("[TB] FAIL grant_cycle_stall: got %b expected %b", stall, doF | doD);
        else passes++;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            c = 0;
            done = 1'b0;
            while (!done) begin
                ack  = (c == lat[k] - 1);
                tmo  = (c == TO);
                done = ack || tmo;
                rd   = ack ? (isF[k] ? rdF : rdD) : $urandom;
                @(negedge clk);
                memAck = ack; memRdata = rd;
                #1;
                if (isF[k]) expData = ack ? rd : '0;
                else        expData = (ack && !we) ? rd : '0;
                checks++;
                if (memReq !== 1'b1) $display("[TB] FAIL access_mem_req: got %b expected 1", memReq);
                else passes++;
                checks++;
                if (memSelect !== isF[k]) $display("[TB] FAIL access_select: got %b expected %b", memSelect, isF[k]);
                else passes++;
                checks++;
                if (memAddr !== (isF[k] ? pc : addr)) $display("[TB] FAIL access_addr: got %h expected %h", memAddr, isF[k] ? pc : addr);
                else passes++;
                if (!isF[k]) begin
                    checks++;
                    if (memWdata !== wd) $display("[TB] FAIL access_wdata: got %h expected %h", memWdata, wd);
                    else passes++;
                end
                checks++;
                if (memWren !== (!isF[k] && we)) $display("[TB] FAIL access_wren: got %b expected %b", memWren, !isF[k] && we);
                else passes++;
                checks++;
                if (ifReady !== (isF[k] && done)) $display("[TB] FAIL if_ready: got %b expected %b (cycle %0d)", ifReady, isF[k] && done, c);
                else passes++;
                checks++;
                if (dmReady !== (!isF[k] && done)) $display("[TB] FAIL dm_ready: got %b expected %b (cycle %0d)", dmReady, !isF[k] && done, c);
                else passes++;
                checks++;
                if (ifInstr !== (isF[k] ? expData : '0)) $display("[TB] FAIL if_instr: got %h expected %h", ifInstr, isF[k] ? expData : '0);
                else passes++;
                checks++;
                if (dmRdata !== (isF[k] ? '0 : expData)) $display("[TB] FAIL dm_rdata: got %h expected %h", dmRdata, isF[k] ? '0 : expData);
                else passes++;
                checks++;
                if (stall !== ((ifReq && !(isF[k] && done)) || (dmReq && !(!isF[k] && done))))
                    $display("[TB] FAIL access_stall: got %b", stall);
                else passes++;
                checks++;
                if (err !== expErr) $display("[TB] FAIL access_err: got %b expected %b", err, expErr);
                else passes++;
                @(posedge clk); #1;
                memAck = 1'b0;
                if (tmo && !ack) expErr = 1'b1;
                if (done) begin
                    if (isF[k]) ifReq = 1'b0;
                    else        dmReq = 1'b0;
                end
                c++;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0) $display("[TB] FAIL back_to_idle_mem_req: got %b expected 0", memReq);
        else passes++;
        checks++;
        if ((ifReady | dmReady | stall) !== 1'b0) $display("[TB] FAIL idle_strobes: got ready %b/%b stall %b expected 0", ifReady, dmReady, stall);
        else passes++;
        checks++;
        if (err !== expErr) $display("[TB] FAIL idle_err: got %b expected %b", err, expErr);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ifReq = 1'b0; ifPc = '0; dmReq = 1'b0; dmWe = 1'b0;
        dmAddr = '0; dmWdata = '0; memAck = 1'b0; memRdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expErr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({memReq, memSelect, memWren, err} !== 4'b0000) $display("[TB] FAIL reset_ctrl: got %b expected 0000", {memReq, memSelect, memWren, err});
        else passes++;
        checks++;
        if (memAddr !== '0 || memWdata !== '0) $display("[TB] FAIL reset_datapath: got %h/%h expected 0/0", memAddr, memWdata);
        else passes++;
        checks++;
        if ({ifReady, dmReady} !== 2'b00 || ifInstr !== '0 || dmRdata !== '0) $display("[TB] FAIL reset_ready: got %b%b expected 00", ifReady, dmReady);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        run_batch(1'b1, 1'b0, 30'd5, 30'd0, 32'd0, 1'b0, 32'h00430820, 32'd0, 1, 1);
    endtask

    task automatic test_back_to_back();
        run_batch(1'b1, 1'b1, 30'd7, 30'd4, 32'h1234_5678, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002, 2, 2);
    endtask

    task automatic test_store();
        run_batch(1'b0, 1'b1, 30'd0, 30'd16, 32'hDEADBEEF, 1'b1, 32'd0, 32'h5555_AAAA, 1, 3);
    endtask

    task automatic test_ack_at_timeout();
        run_batch(1'b1, 1'b0, 30'd40, 30'd0, 32'd0, 1'b0, 32'hC0DE_0040, 32'd0, TO + 1, 1);
        run_batch(1'b0, 1'b1, 30'd0, 30'd41, 32'd9, 1'b0, 32'd0, 32'hC0DE_0041, 1, TO + 1);
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        memAck = 1'b1; memRdata = 32'hFFFF_0000;
        #1;
        checks++;
        if ({ifReady, dmReady} !== 2'b00 || ifInstr !== '0 || dmRdata !== '0) $display("[TB] FAIL idle_ack_ready: got %b%b expected 00", ifReady, dmReady);
        else passes++;
        @(posedge clk); #1 memAck = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0) $display("[TB] FAIL idle_ack_state: got mem_req %b expected 0", memReq);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        run_batch(1'b1, 1'b0, 30'd100, 30'd0, 32'd0, 1'b0, 32'h1111_1111, 32'd0, 1000, 1);
        checks++;
        if (err !== 1'b1) $display("[TB] FAIL timeout_err_set: got %b expected 1", err);
        else passes++;
        run_batch(1'b1, 1'b0, 30'd101, 30'd0, 32'd0, 1'b0, 32'h2222_2222, 32'd0, 2, 1);
    endtask

    task automatic test_reset_mid_access();
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 30'd9; dmWdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (memWren !== 1'b1) $display("[TB] FAIL mid_reset_wren_before: got %b expected 1", memWren);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1; memAck = 1'b1; memRdata = 32'h7777_7777;
        @(negedge clk); #1;
        checks++;
        if (dmReady !== 1'b0) $display("[TB] FAIL mid_reset_no_ready: got %b expected 0", dmReady);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0; memAck = 1'b0; dmReq = 1'b0; expErr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({memReq, memWren, err, dmReady} !== 4'b0000) $display("[TB] FAIL mid_reset_after: got %b expected 0000", {memReq, memWren, err, dmReady});
        else passes++;
        @(posedge clk); #1 memAck = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({ifReady, dmReady} !== 2'b00) $display("[TB] FAIL late_ack_ready: got %b%b expected 00", ifReady, dmReady);
        else passes++;
        @(posedge clk); #1 memAck = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (memReq !== 1'b0) $display("[TB] FAIL late_ack_state: got %b expected 0", memReq);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            run_batch(kind != 1, kind != 0, AW'($urandom), AW'($urandom), $urandom,
                      1'($urandom), $urandom, $urandom,
                      $urandom_range(1, TO + 4), $urandom_range(1, TO + 4));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store();
        test_ack_at_timeout();
        test_spurious_ack();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Requester-side controller for the unified single-port instruction/data memory.
- Sits between the fetch stage and memory stage on one side, and the shared memory port (select / addr / data / wren) on the other.
- Serialises fetch and data requests with a req/ack handshake that tolerates variable memory latency.
- Generates pipeline stall, and aborts hung accesses after a timeout.

Parameters:
- ADDR_W, 30, word-address width (PC and data address, word-granular).
- DATA_W, 32, data/instruction width.
- TIMEOUT, 15, max cycles from mem_req assertion to mem_ack before abort (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request, level, held until if_ready.
- if_pc  in  ADDR_W  fetch word address.
- if_ready  out  1  fetch completion strobe (1 cycle).
- if_instr  out  DATA_W  fetched instruction, valid with if_ready.
- dm_req  in  1  data request, level, held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_ready  out  1  data completion strobe (1 cycle).
- dm_rdata  out  DATA_W  load data, valid with dm_ready.
- mem_req  out  1  memory access in progress.
- mem_select  out  1  1 = fetch (address is PC), 0 = data address.
- mem_addr  out  ADDR_W  latched access address.
- mem_wdata  out  DATA_W  latched store data.
- mem_wren  out  1  write enable; only in DATA state with latched we = 1.
- mem_ack  in  1  memory completion, 1 cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready).
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset: state IDLE; mem_req, mem_select, mem_wren, mem_addr, mem_wdata = 0; counter = 0; err = 0; if_ready, dm_ready = 0; if_instr, dm_rdata = 0. Reset mid-access abandons it silently, with no ready strobe.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - dm_req wins over if_req (older instruction first).
  - On grant, register addr, wdata and we into the mem_* outputs, assert mem_req next cycle, and clear the counter.
  - Grant latency: request at edge N, mem_req high after edge N.
- FETCH / DATA:
  - mem_* outputs are held constant.
  - Counter increments each cycle without mem_ack.
  - Requester inputs are ignored after latching.
- Completion:
  - In the mem_ack cycle, the matching ready is combinationally high.
  - Data passthrough: if_instr = mem_rdata (FETCH); dm_rdata = mem_rdata on a load, 0 on a store.
  - ready and data are 0 outside completion cycles.
- Next state at the ack edge (alternation / chaining):
  - FETCH + dm_req high → DATA, latched immediately with zero idle cycles.
  - DATA + if_req high → FETCH, latched immediately with zero idle cycles.
  - Otherwise → IDLE.
  - The just-completed requester is never re-granted on its own ack edge, so a held req is not double-served.
- Timeout:
  - Counter reaches TIMEOUT with no mem_ack → matching ready pulses that cycle with data 0 (reads as NOP / zero load).
  - err sets; mem_req drops; next state follows the same chaining rule.
  - mem_ack arriving in the same cycle as the timeout counts as normal completion, and err is not set.
- mem_ack while IDLE is ignored: no ready, no state change.
- mem_ack arriving in the first mem_req cycle is legal (latency 1).
- Stores: mem_wren = mem_req & DATA & latched we. It is never high during FETCH or IDLE.
- stall is purely combinational from the inputs and ready signals.

Test Plan:
- Fetch only: memory acks 1 cycle after mem_req; if_pc = 5, mem_rdata = 32'h00430820 → mem_select = 1, mem_addr = 5, if_ready for 1 cycle with if_instr = 32'h00430820, stall low the following cycle once if_req drops.
- Simultaneous if_req (pc = 7) and dm_req load (addr = 4) in IDLE → DATA first (mem_select = 0, addr = 4). On ack, chains straight to FETCH (addr = 7) with no IDLE cycle; dm_ready precedes if_ready by exactly the memory latency.
- Store: dm_we = 1, dm_addr = 16, dm_wdata = 32'hDEADBEEF, ack after 3 cycles → mem_wren high for exactly 3 cycles with mem_wdata = 32'hDEADBEEF, dm_ready with dm_rdata = 0, mem_wren never high in FETCH.
- Timeout: TIMEOUT = 15, fetch with no ack → at the 15th counter value if_ready pulses with if_instr = 0, err = 1 and stays 1, mem_req drops; a later normal fetch completes correctly with err still 1.
- Reset mid-access: rst during DATA cycle 2 → next cycle mem_req = 0, mem_wren = 0, err = 0, no dm_ready; a late mem_ack while IDLE produces no ready.
- Spurious and edge acks: mem_ack in IDLE ignored; mem_ack coinciding with the timeout cycle → normal data returned, err stays 0.
